// File: rtl/song_reader.sv
// Song reader: walks one song of the external synchronous song ROM and hands each {note, duration} to the note player.
// Optional build macro SONG_END_MARKER_EN: a duration==0 entry ends the song early instead of being played.
module song_reader #(
    parameter int NOTE_ADDR_W = 5,
    parameter int NOTE_W      = 6,
    parameter int DUR_W       = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      reset_player,
    input  logic [1:0]                song,
    input  logic                      note_done,
    output logic [NOTE_ADDR_W+1:0]    rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]   rom_data,
    output logic [NOTE_W-1:0]         note,
    output logic [DUR_W-1:0]          duration,
    output logic                      new_note,
    output logic                      song_done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_NOTE = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [NOTE_ADDR_W-1:0]  note_index_r, note_index_s;
    logic [NOTE_W-1:0]       note_r, note_s;
    logic [DUR_W-1:0]        duration_r, duration_s;
    logic                    new_note_r, new_note_s;
    logic                    song_done_r, song_done_s;
    logic [NOTE_W-1:0]       rom_note_s;
    logic [DUR_W-1:0]        rom_dur_s;
    logic                    last_index_s;
    logic                    end_marker_s;

    assign rom_note_s   = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur_s    = rom_data[DUR_W-1:0];
    assign last_index_s = (note_index_r == {NOTE_ADDR_W{1'b1}});

`ifdef SONG_END_MARKER_EN
    assign end_marker_s = (rom_dur_s == {DUR_W{1'b0}});
`else
    assign end_marker_s = 1'b0;
`endif

    // ROM address is combinational so the ROM sees the new index the cycle FETCH is entered.
    assign rom_addr  = {song, note_index_r};
    assign note      = note_r;
    assign duration  = duration_r;
    assign new_note  = new_note_r;
    assign song_done = song_done_r;

    // Next-state, index and output-pulse decode; reset_player outranks every other input.
    always_comb begin
        state_s      = state_r;
        note_index_s = note_index_r;
        note_s       = note_r;
        duration_s   = duration_r;
        new_note_s   = 1'b0;
        song_done_s  = 1'b0;
        if (reset_player) begin
            state_s      = ST_IDLE;
            note_index_s = {NOTE_ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (play) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_s = ST_ISSUE;
                end
                ST_ISSUE: begin
                    // While paused the address is unchanged, so rom_data stays valid here.
                    if (play) begin
                        if (end_marker_s) begin
                            note_index_s = {NOTE_ADDR_W{1'b0}};
                            song_done_s  = 1'b1;
                            state_s      = ST_DONE;
                        end else begin
                            note_s     = rom_note_s;
                            duration_s = rom_dur_s;
                            new_note_s = 1'b1;
                            state_s    = ST_WAIT_NOTE;
                        end
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end
                ST_WAIT_NOTE: begin
                    if (note_done) begin
                        if (last_index_s) begin
                            note_index_s = {NOTE_ADDR_W{1'b0}};
                            song_done_s  = 1'b1;
                            state_s      = ST_DONE;
                        end else begin
                            note_index_s = note_index_r + {{(NOTE_ADDR_W-1){1'b0}}, 1'b1};
                            state_s      = ST_FETCH;
                        end
                    end else begin
                        state_s = ST_WAIT_NOTE;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s      = ST_IDLE;
                    note_index_s = {NOTE_ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // State, index and registered outputs with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            note_index_r <= {NOTE_ADDR_W{1'b0}};
            note_r       <= {NOTE_W{1'b0}};
            duration_r   <= {DUR_W{1'b0}};
            new_note_r   <= 1'b0;
            song_done_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            note_index_r <= note_index_s;
            note_r       <= note_s;
            duration_r   <= duration_s;
            new_note_r   <= new_note_s;
            song_done_r  <= song_done_s;
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: random ROM contents, reference sequence of note/done events pushed into a scoreboard, monitor compares.
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play = 1'b0;
    logic        reset_player = 1'b0;
    logic        note_done = 1'b0;
    logic [1:0]  song = 2'd2;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data = 12'd0;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        new_note;
    logic        song_done;

    logic [11:0] rom_mem [0:127];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          nn_seen = 0;
    int          done_seen = 0;
    logic [5:0]  last_note = 6'd0;
    logic [5:0]  last_dur = 6'd0;

    typedef struct {
        bit         is_done;
        logic [6:0] addr;
        logic [5:0] note;
        logic [5:0] dur;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    song_reader #(.NOTE_ADDR_W(5), .NOTE_W(6), .DUR_W(6)) dut (
        .clk(clk), .reset(reset), .play(play), .reset_player(reset_player),
        .song(song), .note_done(note_done), .rom_addr(rom_addr), .rom_data(rom_data),
        .note(note), .duration(duration), .new_note(new_note), .song_done(song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Song length from the ROM contents: full 32 entries, or up to the first zero-duration entry when markers are enabled.
    function automatic int song_len(input logic [1:0] s);
        int len = 32;
`ifdef SONG_END_MARKER_EN
        for (int i = 31; i >= 0; i--) begin
            if (rom_mem[{s, 5'(i)}][5:0] == 6'd0) len = i;
        end
`endif
        return len;
    endfunction

    task automatic push_note(input logic [1:0] s, input int idx, input int at);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = {s, 5'(idx)};
        e.note    = rom_mem[e.addr][11:6];
        e.dur     = rom_mem[e.addr][5:0];
        e.at      = at;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [1:0] s, input int at);
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = {s, 5'd0};
        e.note    = 6'd0;
        e.dur     = 6'd0;
        e.at      = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_out(input int base, input string name, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (nn_seen + done_seen > base) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no output within 300 cycles, expected one (cycle %0d)", name, cyc);
            exp_q.delete();
        end
    endtask

    // mode: 0 plain, 1 pause at index 4, 2 reset_player with note_done at index 7,
    // 3 reset_player while in DONE, 4 async reset in WAIT_NOTE at index 2.
    task automatic run_song(input logic [1:0] s, input int mode);
        int len, base, width, n;
        bit ok, marker;
        if (song != s) begin
            song = s;
            reset_player = 1'b1;
            step(1);
            reset_player = 1'b0;
        end
        len    = song_len(s);
        marker = (len < 32);
        base   = nn_seen + done_seen;
        play   = 1'b1;
        if (len == 0) push_done(s, cyc + 3);
        else          push_note(s, 0, cyc + 3);
        step(1);
        check("fetch_rom_addr", 32'(rom_addr), 32'({s, 5'd0}));
        for (int i = 0; i < len; i++) begin
            wait_out(base, "new_note", ok);
            if (!ok) begin
                play = 1'b0;
                return;
            end
            if (mode == 4 && i == 2) begin
                reset = 1'b0;
                #1;
                check("async_reset_note", 32'(note), 32'd0);
                check("async_reset_duration", 32'(duration), 32'd0);
                check("async_reset_new_note", 32'(new_note), 32'd0);
                check("async_reset_song_done", 32'(song_done), 32'd0);
                check("async_reset_rom_addr", 32'(rom_addr), 32'({s, 5'd0}));
                exp_q.delete();
                play = 1'b0;
                step(2);
                reset = 1'b1;
                step(1);
                return;
            end
            if (mode == 1 && i == 4) play = 1'b0;
            step($urandom_range(0, 4));
            base = nn_seen + done_seen;
            if (mode == 2 && i == 7) begin
                reset_player = 1'b1;
                note_done    = 1'b1;
                play         = 1'b0;
                step(1);
                reset_player = 1'b0;
                note_done    = 1'b0;
                step(8);
                check("silent_after_reset_player", 32'(nn_seen + done_seen), 32'(base));
                check("note_held_after_reset_player", 32'(note), 32'(last_note));
                check("dur_held_after_reset_player", 32'(duration), 32'(last_dur));
                check("rom_addr_after_reset_player", 32'(rom_addr), 32'({s, 5'd0}));
                return;
            end
            n = cyc;
            note_done = 1'b1;
            width = $urandom_range(1, 2);
            if (i < len - 1) begin
                if (!(mode == 1 && i == 4)) push_note(s, i + 1, n + 3);
            end else begin
                push_done(s, marker ? n + 3 : n + 1);
            end
            step(width);
            note_done = 1'b0;
            if (mode == 1 && i == 4) begin
                step(10);
                check("silent_while_paused", 32'(nn_seen + done_seen), 32'(base));
                play = 1'b1;
                push_note(s, 5, cyc + 1);
            end
        end
        wait_out(base, "song_done", ok);
        play = 1'b0;
        if (ok && mode == 3) begin
            base = nn_seen + done_seen;
            reset_player = 1'b1;
            step(1);
            reset_player = 1'b0;
            check("song_done_one_cycle", 32'(song_done), 32'd0);
            step(4);
            check("no_second_song_done", 32'(nn_seen + done_seen), 32'(base));
        end
        step(2);
    endtask

    initial begin
        for (int a = 0; a < 128; a++) begin
            rom_mem[a] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
        end
        rom_mem[3][5:0] = 6'd0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (new_note || song_done) begin
                        if (new_note && song_done) check("pulse_exclusive", 32'd1, 32'd0);
                        if (exp_q.size() == 0) begin
                            check("unexpected_output", 32'({song_done, new_note}), 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("event_kind", 32'(song_done), 32'(e.is_done));
                            check("event_rom_addr", 32'(rom_addr), 32'(e.addr));
                            if (!e.is_done) begin
                                check("note", 32'(note), 32'(e.note));
                                check("duration", 32'(duration), 32'(e.dur));
                                last_note = e.note;
                                last_dur  = e.dur;
                            end
                            if (e.at >= 0) check("event_cycle", 32'(cyc), 32'(e.at));
                        end
                        if (new_note)  nn_seen++;
                        if (song_done) done_seen++;
                    end
                end
            end
        join_none

        step(2);
        check("reset_note", 32'(note), 32'd0);
        check("reset_duration", 32'(duration), 32'd0);
        check("reset_new_note", 32'(new_note), 32'd0);
        check("reset_song_done", 32'(song_done), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'h40);
        reset = 1'b1;
        step(1);

        run_song(2'd2, 0);
        run_song(2'd1, 0);
        run_song(2'd0, 0);
        run_song(2'd3, 1);
        run_song(2'd1, 2);
        run_song(2'd1, 3);
        run_song(2'd2, 4);
        run_song(2'd2, 0);
        repeat (3) run_song(2'($urandom_range(0, 3)), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
